pu_msp430_wakeup_ctrl: RTL and testbench



---
 rtl/pu_msp430_pkg.sv | 14 +
 rtl/pu_msp430_sync_cell.sv | 24 ++
 rtl/pu_msp430_wakeup_ctrl.sv | 106 ++++++++++
 tb/tb_pu_msp430_wakeup_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pu_msp430_pkg.sv
// Shared types and constants for the MSP430 power-unit wakeup path.
package pu_msp430_pkg;

   localparam int WKUP_CNT_W   = 8;
   localparam int WKUP_CLR_MIN = 2;

   typedef enum logic [1:0] {
      IDLE,
      STAB,
      REQ,
      CLEAR
   } wkup_state_t;

endpackage

// File: rtl/pu_msp430_sync_cell.sv
// Two-flop synchroniser with asynchronous active-low reset; reusable for any
// single-bit level crossing into the clk domain.
module pu_msp430_sync_cell (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   // NOTE: sequential state uses non-blocking assignments so both stages
   // sample the pre-edge values and the chain really is two flops deep.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pu_msp430_wakeup_ctrl.sv
// Wakeup controller: synchronises the wakeup latch, restarts clocks, handshakes
// with the frontend and clears the latch. Optional counter: PU_MSP430_WKUP_CNT_EN.
module pu_msp430_wakeup_ctrl
   import pu_msp430_pkg::*;
#(
   parameter int unsigned STAB_CYCLES = 4
) (
   input  logic                  mclk,
   input  logic                  reset_n,
   input  logic                  wkup_async,
   input  logic                  wkup_ack,
   input  logic                  cnt_clr,
   output logic                  wkup_clear,
   output logic                  clk_restart,
   output logic                  wkup_req,
   output logic                  busy,
   output logic [WKUP_CNT_W-1:0] wkup_cnt
);

   localparam logic [WKUP_CNT_W-1:0] STAB_LOAD = WKUP_CNT_W'(STAB_CYCLES - 1);
   localparam logic [WKUP_CNT_W-1:0] CLR_LOAD  = WKUP_CNT_W'(WKUP_CLR_MIN - 1);

   wkup_state_t           state, state_nxt;
   logic [WKUP_CNT_W-1:0] tmr, tmr_nxt;
   logic                  wkup_sync;
   logic                  start;

   pu_msp430_sync_cell u_sync (
      .clk   (mclk),
      .rst_n (reset_n),
      .d     (wkup_async),
      .q     (wkup_sync)
   );

   assign start = (state == IDLE) && wkup_sync;

   // One down-counter serves both the stabilisation window and the minimum
   // CLEAR hold, since the two phases never overlap.
   // NOTE: every combinational output gets a default first so no path can
   // infer a latch.
   always_comb begin
      state_nxt = state;
      tmr_nxt   = tmr;
      unique case (state)
         IDLE: begin
            if (wkup_sync) begin
               state_nxt = STAB;
               tmr_nxt   = STAB_LOAD;
            end
         end
         STAB: begin
            if (tmr == '0) state_nxt = REQ;
            else           tmr_nxt   = tmr - 1'b1;
         end
         REQ: begin
            if (wkup_ack) begin
               state_nxt = CLEAR;
               tmr_nxt   = CLR_LOAD;
            end
         end
         CLEAR: begin
            if (tmr != '0)      tmr_nxt   = tmr - 1'b1;
            else if (!wkup_sync) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are flopped from the next state so they track the state register
   // exactly and cannot glitch.
   always_ff @(posedge mclk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         tmr         <= '0;
         wkup_clear  <= 1'b0;
         clk_restart <= 1'b0;
         wkup_req    <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_nxt;
         tmr         <= tmr_nxt;
         wkup_clear  <= (state_nxt == CLEAR);
         clk_restart <= (state_nxt == STAB) || (state_nxt == REQ);
         wkup_req    <= (state_nxt == REQ);
         busy        <= (state_nxt != IDLE);
      end
   end

`ifdef PU_MSP430_WKUP_CNT_EN
   logic [WKUP_CNT_W-1:0] cnt;

   always_ff @(posedge mclk or negedge reset_n) begin
      if (!reset_n)                    cnt <= '0;
      else if (cnt_clr)                cnt <= '0;
      else if (start && (cnt != '1))   cnt <= cnt + 1'b1;
   end

   assign wkup_cnt = cnt;
`else
   logic unused_cnt;

   assign unused_cnt = cnt_clr ^ start;
   assign wkup_cnt   = '0;
`endif

endmodule

// File: tb/tb_pu_msp430_wakeup_ctrl.sv
// Directed self-checking bench for pu_msp430_wakeup_ctrl; follows
// PU_MSP430_WKUP_CNT_EN for the expected counter value.
module tb_pu_msp430_wakeup_ctrl;

   localparam int unsigned STAB = 4;
`ifdef PU_MSP430_WKUP_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic       mclk = 1'b0;
   logic       reset_n;
   logic       wkup_async;
   logic       wkup_ack;
   logic       cnt_clr;
   logic       wkup_clear;
   logic       clk_restart;
   logic       wkup_req;
   logic       busy;
   logic [7:0] wkup_cnt;

   logic       latch = 1'b0;
   logic       stuck = 1'b0;
   int         n_cmp = 0;
   int         n_err = 0;
   int         exp_cnt = 0;

   pu_msp430_wakeup_ctrl #(.STAB_CYCLES(STAB)) dut (
      .mclk        (mclk),
      .reset_n     (reset_n),
      .wkup_async  (wkup_async),
      .wkup_ack    (wkup_ack),
      .cnt_clr     (cnt_clr),
      .wkup_clear  (wkup_clear),
      .clk_restart (clk_restart),
      .wkup_req    (wkup_req),
      .busy        (busy),
      .wkup_cnt    (wkup_cnt)
   );

   always #5 mclk = ~mclk;

   // Wakeup cell model: set by an event, held clear while wkup_clear is high.
   assign wkup_async = latch | stuck;
   always @(posedge wkup_clear) latch = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge mclk);
      #1;
   endtask

   task automatic wake();
      if (!wkup_clear) latch = 1'b1;
   endtask

   function automatic logic [3:0] outs();
      return {clk_restart, wkup_req, wkup_clear, busy};
   endfunction

   function automatic logic cond(input int sel);
      case (sel)
         0:       return !busy;
         1:       return wkup_req;
         2:       return wkup_clear;
         3:       return clk_restart && !wkup_req;
         default: return busy;
      endcase
   endfunction

   task automatic wait_for(input int sel);
      for (int i = 0; i < 600; i++) begin
         if (cond(sel)) return;
         tick();
      end
      check($sformatf("timeout_%0d", sel), 32'd0, 32'd1);
   endtask

   task automatic check_cnt(input string tag);
      check(tag, {24'd0, wkup_cnt}, CNT_EN ? exp_cnt : 0);
   endtask

   task automatic bump();
      if (exp_cnt < 255) exp_cnt++;
   endtask

   initial begin
      logic [3:0] exp_o;
      int         rises;
      logic       prev;

      reset_n  = 1'b0;
      wkup_ack = 1'b0;
      cnt_clr  = 1'b0;
      #1;
      check("reset_outs", {28'd0, outs()}, 32'd0);
      tick(); tick(); tick();
      check("reset_outs_held", {28'd0, outs()}, 32'd0);
      check_cnt("reset_cnt");
      reset_n = 1'b1;
      tick();
      check("post_reset_outs", {28'd0, outs()}, 32'd0);

      // Basic sequence with ack held high throughout; i counts cycles from the rise.
      wkup_ack = 1'b1;
      wake();
      for (int i = 0; i <= 12; i++) begin
         exp_o[3] = (i >= 3) && (i <= 7);
         exp_o[2] = (i == 7);
         exp_o[1] = (i >= 8) && (i <= 10);
         exp_o[0] = (i >= 3) && (i <= 10);
         check($sformatf("seq1_c%0d", i), {28'd0, outs()}, {28'd0, exp_o});
         tick();
      end
      bump();
      check_cnt("seq1_cnt");

      // Ack delayed: wkup_req held for 6 cycles.
      wkup_ack = 1'b0;
      wake();
      wait_for(1);
      for (int k = 0; k < 5; k++) begin
         check($sformatf("req_hold_%0d", k), {31'd0, wkup_req}, 32'd1);
         tick();
      end
      wkup_ack = 1'b1;
      check("req_hold_5", {31'd0, wkup_req}, 32'd1);
      tick();
      wkup_ack = 1'b0;
      check("req_to_clear", {30'd0, wkup_req, wkup_clear}, 32'd1);
      wait_for(0);
      bump();

      // Second event during STAB merges into one sequence.
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      exp_cnt  = 0;
      wkup_ack = 1'b1;
      wake();
      wait_for(3);
      tick();
      wake();
      rises = 0;
      prev  = wkup_clear;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (wkup_clear && !prev) rises++;
         prev = wkup_clear;
      end
      bump();
      check("merge_one_clear", rises, 32'd1);
      check_cnt("merge_cnt");

      // Reset during REQ with the latch still set.
      wkup_ack = 1'b0;
      wake();
      wait_for(1);
      reset_n = 1'b0;
      #1;
      check("rst_req_outs", {28'd0, outs()}, 32'd0);
      exp_cnt = 0;
      check_cnt("rst_req_cnt");
      tick();
      check("rst_req_outs_held", {28'd0, outs()}, 32'd0);
      reset_n = 1'b1;
      tick();
      check("rel_c1", {28'd0, outs()}, 32'd0);
      tick();
      check("rel_c2", {28'd0, outs()}, 32'd0);
      tick();
      check("rel_c3_stab", {28'd0, outs()}, 32'b1001);
      bump();
      check_cnt("rel_cnt");
      wkup_ack = 1'b1;
      wait_for(0);

      // Counter saturation over 256 sequences.
      for (int s = 0; s < 256; s++) begin
         wake();
         wait_for(4);
         wait_for(0);
         bump();
      end
      check_cnt("sat_cnt");

      // cnt_clr coincident with IDLE->STAB wins.
      wake();
      tick();
      tick();
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      exp_cnt = 0;
      check("clr_start_busy", {31'd0, busy}, 32'd1);
      check_cnt("clr_start_cnt");
      wait_for(0);
      wake();
      wait_for(4);
      bump();
      check_cnt("after_clr_cnt");
      wait_for(0);

      // Latch that fails to clear: CLEAR holds until wkup_sync drops.
      wake();
      wait_for(2);
      stuck = 1'b1;
      for (int k = 0; k < 10; k++) begin
         check($sformatf("stuck_clear_%0d", k), {31'd0, wkup_clear}, 32'd1);
         tick();
      end
      stuck = 1'b0;
      check("unstuck_c0", {31'd0, wkup_clear}, 32'd1);
      tick();
      check("unstuck_c1", {31'd0, wkup_clear}, 32'd1);
      tick();
      check("unstuck_c2", {31'd0, wkup_clear}, 32'd1);
      tick();
      check("unstuck_exit", {28'd0, outs()}, 32'd0);
      bump();
      check_cnt("final_cnt");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
